pocket_scheduler: RTL and testbench

POCKET_SCHEDULER -- requirements
Module: pocket_scheduler

---
 rtl/pocket_scheduler_pkg.sv | 35 +++
 rtl/pocket_scheduler_dist.sv | 35 +++
 rtl/pocket_scheduler.sv | 133 +++++++++++++
 tb/tb_pocket_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pocket_scheduler_pkg.sv
// rtl/pocket_scheduler_pkg.sv - shared geometry constants, hole table and FSM states
package pocket_scheduler_pkg;

    localparam int NUM_HOLES = 6;
    localparam int HOLE_SIZE = 32;
    localparam int BALL_SIZE = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Hole top-left table: columns at x = 0/304/608, rows at y = 0/448.
    function automatic logic [11:0] hole_cx(input logic [2:0] h);
        logic [10:0] tl;
        case (h)
            3'd1, 3'd4: tl = 11'd304;
            3'd2, 3'd5: tl = 11'd608;
            default:    tl = 11'd0;
        endcase
        return {1'b0, tl} + 12'(HOLE_SIZE / 2);
    endfunction

    function automatic logic [11:0] hole_cy(input logic [2:0] h);
        logic [10:0] tl;
        case (h)
            3'd3, 3'd4, 3'd5: tl = 11'd448;
            default:          tl = 11'd0;
        endcase
        return {1'b0, tl} + 12'(HOLE_SIZE / 2);
    endfunction

endpackage

// File: rtl/pocket_scheduler_dist.sv
// rtl/pocket_scheduler_dist.sv - combinational squared-distance pocket test
module pocket_dist_check #(
    parameter int RADIUS_SQ = 144
) (
    input  logic signed [11:0] ball_cx,
    input  logic signed [11:0] ball_cy,
    input  logic signed [11:0] hole_cx,
    input  logic signed [11:0] hole_cy,
    output logic               hit
);

    logic signed [11:0] dx;
    logic signed [11:0] dy;
    logic signed [23:0] dx_w;
    logic signed [23:0] dy_w;
    logic signed [23:0] prod_x;
    logic signed [23:0] prod_y;
    logic        [21:0] sq_x;
    logic        [21:0] sq_y;
    logic        [22:0] sum;

    always_comb begin
        dx     = ball_cx - hole_cx;
        dy     = ball_cy - hole_cy;
        dx_w   = {{12{dx[11]}}, dx};
        dy_w   = {{12{dy[11]}}, dy};
        prod_x = dx_w * dx_w;
        prod_y = dy_w * dy_w;
        sq_x   = prod_x[21:0];
        sq_y   = prod_y[21:0];
        sum    = {1'b0, sq_x} + {1'b0, sq_y};
        hit    = (sum < 23'(RADIUS_SQ));
    end

endmodule

// File: rtl/pocket_scheduler.sv
// rtl/pocket_scheduler.sv - per-frame ball/hole scan reporting pocketed balls one at a time
module pocket_scheduler
    import pocket_scheduler_pkg::*;
#(
    parameter int NUM_BALLS        = 16,
    parameter int POCKET_RADIUS_SQ = 144
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [NUM_BALLS-1:0][10:0]   ballX,
    input  logic [NUM_BALLS-1:0][10:0]   ballY,
    input  logic [NUM_BALLS-1:0]         ballActive,
    input  logic                         pocketReady,
    output logic                         pocketValid,
    output logic [$clog2(NUM_BALLS)-1:0] pocketBall,
    output logic [2:0]                   pocketHole,
    output logic                         busy,
    output logic                         scanDone,
    output logic                         frameOverrun
);

    localparam int BW = $clog2(NUM_BALLS);

    state_e                       state_q, state_d;
    logic [BW-1:0]                ball_q, ball_d;
    logic [2:0]                   hole_q, hole_d;
    logic [NUM_BALLS-1:0][10:0]   snap_x_q, snap_x_d;
    logic [NUM_BALLS-1:0][10:0]   snap_y_q, snap_y_d;
    logic [NUM_BALLS-1:0]         snap_act_q, snap_act_d;
    logic                         overrun_q, overrun_d;

    logic signed [11:0] ball_cx;
    logic signed [11:0] ball_cy;
    logic               dist_hit;
    logic               hit;
    logic               last_ball;

    assign ball_cx   = {snap_x_q[ball_q][10], snap_x_q[ball_q]} + 12'(BALL_SIZE / 2);
    assign ball_cy   = {snap_y_q[ball_q][10], snap_y_q[ball_q]} + 12'(BALL_SIZE / 2);
    assign hit       = dist_hit && snap_act_q[ball_q];
    assign last_ball = (ball_q == BW'(NUM_BALLS - 1));

    pocket_dist_check #(
        .RADIUS_SQ (POCKET_RADIUS_SQ)
    ) u_dist (
        .ball_cx (ball_cx),
        .ball_cy (ball_cy),
        .hole_cx (hole_cx(hole_q)),
        .hole_cy (hole_cy(hole_q)),
        .hit     (dist_hit)
    );

    always_comb begin
        state_d    = state_q;
        ball_d     = ball_q;
        hole_d     = hole_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_act_d = snap_act_q;
        overrun_d  = startOfFrame && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (startOfFrame) begin
                    snap_x_d   = ballX;
                    snap_y_d   = ballY;
                    snap_act_d = ballActive;
                    ball_d     = '0;
                    hole_d     = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A hit freezes ball/hole so REPORT can present them directly.
                if (hit) begin
                    state_d = ST_REPORT;
                end else if (hole_q == 3'(NUM_HOLES - 1)) begin
                    if (last_ball) begin
                        state_d = ST_DONE;
                    end else begin
                        ball_d = ball_q + 1'b1;
                        hole_d = '0;
                    end
                end else begin
                    hole_d = hole_q + 3'd1;
                end
            end
            ST_REPORT: begin
                if (pocketReady) begin
                    if (last_ball) begin
                        state_d = ST_DONE;
                    end else begin
                        ball_d  = ball_q + 1'b1;
                        hole_d  = '0;
                        state_d = ST_SCAN;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ball_q     <= '0;
            hole_q     <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_act_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_q     <= ball_d;
            hole_q     <= hole_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_act_q <= snap_act_d;
            overrun_q  <= overrun_d;
        end
    end

    assign pocketValid  = (state_q == ST_REPORT);
    assign pocketBall   = pocketValid ? ball_q : '0;
    assign pocketHole   = pocketValid ? hole_q : '0;
    assign busy         = (state_q != ST_IDLE);
    assign scanDone     = (state_q == ST_DONE);
    assign frameOverrun = overrun_q;

endmodule

// File: tb/tb_pocket_scheduler.sv
// tb/tb_pocket_scheduler.sv - self-checking bench for pocket_scheduler
module tb_pocket_scheduler;

    localparam int NB = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 startOfFrame;
    logic [NB-1:0][10:0]  ballX;
    logic [NB-1:0][10:0]  ballY;
    logic [NB-1:0]        ballActive;
    logic                 pocketReady;
    logic                 pocketValid;
    logic [3:0]           pocketBall;
    logic [2:0]           pocketHole;
    logic                 busy;
    logic                 scanDone;
    logic                 frameOverrun;

    pocket_scheduler #(.NUM_BALLS(NB), .POCKET_RADIUS_SQ(144)) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .ballX        (ballX),
        .ballY        (ballY),
        .ballActive   (ballActive),
        .pocketReady  (pocketReady),
        .pocketValid  (pocketValid),
        .pocketBall   (pocketBall),
        .pocketHole   (pocketHole),
        .busy         (busy),
        .scanDone     (scanDone),
        .frameOverrun (frameOverrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int bx [NB];
    int by [NB];
    bit ba [NB];
    int hx [6] = '{0, 304, 608, 0, 304, 608};
    int hy [6] = '{0, 0, 0, 448, 448, 448};

    int ev_b[$];
    int ev_h[$];
    int exp_base;
    int obs_b[$];
    int obs_h[$];
    int obs_c[$];
    int done_cyc;

    typedef struct {
        int x;
        int y;
        bit act;
        int exp_ball;
        int exp_hole;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_balls();
        for (int i = 0; i < NB; i++) begin
            bx[i] = 900;
            by[i] = 900;
            ba[i] = 1'b0;
        end
    endtask

    task automatic apply_balls();
        for (int i = 0; i < NB; i++) begin
            ballX[i]      = 11'(bx[i]);
            ballY[i]      = 11'(by[i]);
            ballActive[i] = ba[i];
        end
    endtask

    // Reference: scan balls in order, first hole within radius wins; each ball
    // costs 6 cycles without a hit, or (hole+1) scan cycles plus one report cycle.
    function automatic void build_model();
        int dx;
        int dy;
        bit found;
        ev_b.delete();
        ev_h.delete();
        exp_base = 1;
        for (int b = 0; b < NB; b++) begin
            found = 1'b0;
            for (int h = 0; h < 6; h++) begin
                if (!found && ba[b]) begin
                    dx = (bx[b] + 8) - (hx[h] + 16);
                    dy = (by[b] + 8) - (hy[h] + 16);
                    if (dx * dx + dy * dy < 144) begin
                        found = 1'b1;
                        ev_b.push_back(b);
                        ev_h.push_back(h);
                        exp_base += h + 2;
                    end
                end
            end
            if (!found) exp_base += 6;
        end
    endfunction

    task automatic run_scan(input int ready_pct, input int hold, input int ovr_cyc, input bit scramble);
        int cyc;
        int stalls;
        int vcount;
        bit done;
        bit in_report;
        build_model();
        apply_balls();
        obs_b.delete();
        obs_h.delete();
        obs_c.delete();
        done_cyc = -1;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        cyc = 1;
        stalls = 0;
        vcount = 0;
        done = 1'b0;
        in_report = 1'b0;
        while (!done && cyc < 3000) begin
            startOfFrame = (cyc == ovr_cyc);
            if (scramble) begin
                ballX[$urandom_range(NB - 1)] = 11'($urandom);
                ballY[$urandom_range(NB - 1)] = 11'($urandom);
                ballActive = NB'($urandom);
            end
            if (pocketValid) begin
                pocketReady = (vcount >= hold) && ($urandom_range(0, 99) < ready_pct);
                vcount++;
            end else begin
                pocketReady = ($urandom_range(0, 99) < 50);
            end
            if (ovr_cyc > 0 && cyc == ovr_cyc + 1) chk("overrun pulse", frameOverrun, 1);
            if (ovr_cyc > 0 && cyc == ovr_cyc + 2) chk("overrun single", frameOverrun, 0);
            if (pocketValid) begin
                if (!in_report) begin
                    obs_b.push_back(int'(pocketBall));
                    obs_h.push_back(int'(pocketHole));
                    obs_c.push_back(cyc);
                    in_report = 1'b1;
                end
                if (ev_b.size() == 0) begin
                    chk("unexpected event", 1, 0);
                end else begin
                    chk("event ball", pocketBall, ev_b[0]);
                    chk("event hole", pocketHole, ev_h[0]);
                end
                if (pocketReady) begin
                    if (ev_b.size() > 0) begin
                        void'(ev_b.pop_front());
                        void'(ev_h.pop_front());
                    end
                    in_report = 1'b0;
                end else begin
                    stalls++;
                end
            end
            if (scanDone) begin
                done = 1'b1;
                done_cyc = cyc;
                chk("events left", ev_b.size(), 0);
                chk("done cycle", cyc, exp_base + stalls);
            end
            step();
            cyc++;
        end
        startOfFrame = 1'b0;
        pocketReady = 1'b0;
        if (!done) chk("scan timeout", 0, 1);
        else chk("busy after done", busy, 0);
    endtask

    initial begin
        bit bad;
        int n;
        reset = 1'b1;
        startOfFrame = 1'b0;
        pocketReady = 1'b0;
        ballX = '0;
        ballY = '0;
        ballActive = '0;

        vecs[0] = '{x: 20,  y: 8,   act: 1'b1, exp_ball: -1, exp_hole: 0};
        vecs[1] = '{x: 19,  y: 8,   act: 1'b1, exp_ball: 0,  exp_hole: 0};
        vecs[2] = '{x: 8,   y: -3,  act: 1'b1, exp_ball: 0,  exp_hole: 0};
        vecs[3] = '{x: 312, y: 8,   act: 1'b1, exp_ball: 0,  exp_hole: 1};
        vecs[4] = '{x: 616, y: 456, act: 1'b1, exp_ball: 0,  exp_hole: 5};
        vecs[5] = '{x: 16,  y: 16,  act: 1'b1, exp_ball: 0,  exp_hole: 0};
        vecs[6] = '{x: 17,  y: 17,  act: 1'b1, exp_ball: -1, exp_hole: 0};
        vecs[7] = '{x: 8,   y: 8,   act: 1'b0, exp_ball: -1, exp_hole: 0};
        vecs[8] = '{x: 8,   y: 448, act: 1'b1, exp_ball: 0,  exp_hole: 3};

        step();
        step();
        chk("reset valid", pocketValid, 0);
        chk("reset ball", pocketBall, 0);
        chk("reset hole", pocketHole, 0);
        chk("reset busy", busy, 0);
        chk("reset done", scanDone, 0);
        chk("reset overrun", frameOverrun, 0);
        reset = 1'b0;
        step();

        // All balls inactive: full 96-pair scan.
        clear_balls();
        run_scan(100, 0, -1, 1'b0);
        chk("idle scan events", obs_b.size(), 0);
        chk("idle scan done", done_cyc, 97);

        // Ball 3 sitting on hole 0.
        clear_balls();
        bx[3] = 8; by[3] = 8; ba[3] = 1'b1;
        run_scan(100, 0, -1, 1'b0);
        chk("b3 count", obs_b.size(), 1);
        if (obs_b.size() > 0) begin
            chk("b3 cycle", obs_c[0], 20);
            chk("b3 ball", obs_b[0], 3);
            chk("b3 hole", obs_h[0], 0);
        end
        chk("b3 done", done_cyc, 93);

        for (int i = 0; i < 9; i++) begin
            clear_balls();
            bx[0] = vecs[i].x; by[0] = vecs[i].y; ba[0] = vecs[i].act;
            run_scan(100, 0, -1, 1'b0);
            chk($sformatf("vec%0d first ball", i), (obs_b.size() > 0) ? obs_b[0] : -1, vecs[i].exp_ball);
            if (vecs[i].exp_ball >= 0 && obs_b.size() > 0) begin
                chk($sformatf("vec%0d hole", i), obs_h[0], vecs[i].exp_hole);
                chk($sformatf("vec%0d cycle", i), obs_c[0], vecs[i].exp_hole + 2);
            end
        end

        // Ball 2 on hole 4 with ready held low, ball 3 on hole 0 proves the resume point.
        clear_balls();
        bx[2] = 312; by[2] = 456; ba[2] = 1'b1;
        bx[3] = 8;   by[3] = 8;   ba[3] = 1'b1;
        run_scan(100, 10, -1, 1'b1);
        chk("hold count", obs_b.size(), 2);
        if (obs_b.size() == 2) begin
            chk("hold first cycle", obs_c[0], 18);
            chk("hold resume cycle", obs_c[1], 30);
        end
        chk("hold done", done_cyc, 103);

        // Overrun in cycle 40 must not disturb the scan.
        clear_balls();
        run_scan(100, 0, 40, 1'b0);
        chk("overrun scan done", done_cyc, 97);

        // Reset while an event is pending.
        clear_balls();
        bx[3] = 8; by[3] = 8; ba[3] = 1'b1;
        apply_balls();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        pocketReady = 1'b0;
        n = 0;
        while (!pocketValid && n < 40) begin
            step();
            n++;
        end
        chk("pre-reset valid", pocketValid, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid reset valid", pocketValid, 0);
        chk("mid reset ball", pocketBall, 0);
        chk("mid reset hole", pocketHole, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset done", scanDone, 0);
        chk("mid reset overrun", frameOverrun, 0);
        step();
        reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 110; c++) begin
            pocketReady = 1'b1;
            step();
            if (pocketValid || busy || scanDone) bad = 1'b1;
        end
        pocketReady = 1'b0;
        chk("quiet after reset", bad, 0);

        // Randomized frames against the reference.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NB; i++) begin
                ba[i] = ($urandom_range(0, 99) < 60);
                if ($urandom_range(0, 1) == 1) begin
                    int hh;
                    hh = int'($urandom_range(0, 5));
                    bx[i] = hx[hh] + 8 + int'($urandom_range(0, 28)) - 14;
                    by[i] = hy[hh] + 8 + int'($urandom_range(0, 28)) - 14;
                end else begin
                    bx[i] = int'($urandom_range(0, 2047)) - 1024;
                    by[i] = int'($urandom_range(0, 2047)) - 1024;
                end
            end
            run_scan(60, 0, (t % 3 == 0) ? int'($urandom_range(1, 30)) : -1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
